sp_mem_arbiter: RTL and testbench
=================================

Name: sp_mem_arbiter

Overview:
- Sits directly downstream of the AXI-to-SRAM interface and arbitrates its memory request port against the core LSU data port.
- Drives one single-port SRAM macro with 1-cycle read latency.
- The AXI side has no grant signal and must never stall, so it has fixed absolute priority.
- The core side uses a req/gnt/rvalid handshake, holds its read data stable, and gets an error response for out-of-range addresses.

Parameters:
- ADDR_WIDTH, 10, word address width on all three ports.
- DATA_WIDTH, 64, data width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- NUM_WORDS, 1024, implemented depth; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_req_i  in  1  AXI-side request; always served in the same cycle.
- axi_addr_i  in  ADDR_WIDTH  AXI word address.
- axi_we_i  in  1  AXI write enable (1 = write).
- axi_be_i  in  BE_WIDTH  AXI byte enables.
- axi_wdata_i  in  DATA_WIDTH  AXI write data.
- axi_rdata_o  out  DATA_WIDTH  AXI read data, valid the cycle after a read request.
- core_req_i  in  1  core request.
- core_gnt_o  out  1  core grant (combinational).
- core_addr_i  in  ADDR_WIDTH  core word address.
- core_we_i  in  1  core write enable.
- core_be_i  in  BE_WIDTH  core byte enables.
- core_wdata_i  in  DATA_WIDTH  core write data.
- core_rvalid_o  out  1  response valid, one cycle after grant.
- core_rdata_o  out  DATA_WIDTH  core read data, held until the next rvalid.
- core_err_o  out  1  error flag, qualified by core_rvalid_o.
- ram_en_o  out  1  SRAM enable (active high).
- ram_addr_o  out  ADDR_WIDTH  SRAM address.
- ram_we_o  out  1  SRAM write enable.
- ram_be_o  out  BE_WIDTH  SRAM byte enables.
- ram_wdata_o  out  DATA_WIDTH  SRAM write data.
- ram_rdata_i  in  DATA_WIDTH  SRAM read data, 1-cycle latency.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: core_rvalid_o=0, core_err_o=0, core_rdata_o=0, owner=OWN_NONE. All ram_* outputs are combinational and equal 0 when there is no request.
- Arbitration:
  - core_gnt_o = core_req_i & ~axi_req_i.
  - With both requests active, AXI wins; the core keeps req asserted with stable address/data until granted.
- SRAM mux:
  - axi_req_i=1: AXI fields are forwarded, ram_en_o=1.
  - Else, granted core request with in-range address (core_addr_i < NUM_WORDS): core fields are forwarded, ram_en_o=1.
  - Else: ram_en_o=0 and all other ram_* outputs are 0.
- AXI read path: axi_rdata_o = ram_rdata_i pass-through. Timing is as the AXI interface expects: read request in cycle N, data in N+1.
- Owner register, updated every cycle to one of:
  - OWN_NONE
  - OWN_AXI (AXI access)
  - OWN_CORE (granted core access, in range)
  - OWN_CORE_ERR (granted core access, out of range)
- Core response in cycle N+1 after a grant in cycle N:
  - core_rvalid_o=1 for exactly one cycle, for writes as well as reads.
  - OWN_CORE read: core_rdata_o captures ram_rdata_i and core_err_o=0.
  - OWN_CORE write: core_rdata_o is unchanged.
  - OWN_CORE_ERR: core_rdata_o is loaded with 0, core_err_o=1, and the SRAM is not accessed.
- Rdata hold: core_rdata_o only changes in a cycle where core_rvalid_o=1. A subsequent AXI read must not disturb it.
- Back-to-back: a core grant every cycle gives rvalid every cycle. Throughput is 1 access/cycle in total.
- Reset mid-operation: a pending response is dropped (no rvalid after reset deassertion). The owner register returns to OWN_NONE.
- Writes: byte-enables are forwarded unchanged. The block does no read-modify-write.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, two ports are added:
  - perf_clr_i  in  1
  - conflict_cnt_o  out  32
- conflict_cnt_o counts cycles with axi_req_i & core_req_i. It saturates at 32'hFFFF_FFFF, resets to 0, and perf_clr_i clears it synchronously, with priority over increment.
- When undefined, the ports and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package sp_mem_arbiter_pkg holds:
  - owner_e enum: OWN_NONE, OWN_AXI, OWN_CORE, OWN_CORE_ERR.
  - PERF_CNT_WIDTH=32.
- Sub-module sp_mem_arbiter_perf_cnt (saturating counter with clear), instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Core read, AXI idle: core_req=1, addr=0x010 with mem[0x010]=0xDEADBEEF_0000_0001. Expect gnt=1 the same cycle, rvalid=1 next cycle, rdata=0xDEADBEEF_0000_0001, err=0.
- Conflict: AXI write to addr 0x020 and core read of 0x020 issued together. Expect gnt=0 in cycle 0 and the AXI write to reach ram. In cycle 1, gnt=1 and the core reads back the newly written data.
- Out-of-range: NUM_WORDS=512, core read of addr 0x3FF. Expect ram_en_o=0, rvalid=1 next cycle, err=1, rdata=0.
- Rdata hold: core read returns 0xA5..A5, then an AXI read of a different word. core_rdata_o must stay 0xA5..A5 while axi_rdata_o changes.
- Reset mid-operation: grant a core read, then assert rst_n=0 before the next edge. Expect no rvalid after release and all outputs at reset values.
- MEM_ARB_PERF_EN: 5 conflict cycles give conflict_cnt_o=5. perf_clr_i=1 in the same cycle as a conflict gives 0 the next cycle.

Source files
------------

// File: rtl/sp_mem_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Owner encoding records who used the SRAM port in the previous cycle.
package sp_mem_arbiter_pkg;

    localparam int unsigned PERF_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        OWN_NONE     = 2'd0,
        OWN_AXI      = 2'd1,
        OWN_CORE     = 2'd2,
        OWN_CORE_ERR = 2'd3
    } owner_e;

    // True when the previous cycle carried a core access that owes a response.
    function automatic logic owner_is_core(input owner_e owner);
        return (owner == OWN_CORE) || (owner == OWN_CORE_ERR);
    endfunction

endpackage

// File: rtl/sp_mem_arbiter_perf_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Only instantiated when MEM_ARB_PERF_EN is defined.
module sp_mem_arbiter_perf_cnt
    import sp_mem_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [PERF_CNT_WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + PERF_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Arbitrates a never-stalling AXI memory port (absolute priority) against the
// core LSU port onto one single-port SRAM. Optional conflict counter: MEM_ARB_PERF_EN.
module sp_mem_arbiter
    import sp_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_WORDS  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      axi_req_i,
    input  logic [ADDR_WIDTH-1:0]     axi_addr_i,
    input  logic                      axi_we_i,
    input  logic [BE_WIDTH-1:0]       axi_be_i,
    input  logic [DATA_WIDTH-1:0]     axi_wdata_i,
    output logic [DATA_WIDTH-1:0]     axi_rdata_o,

    input  logic                      core_req_i,
    output logic                      core_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     core_addr_i,
    input  logic                      core_we_i,
    input  logic [BE_WIDTH-1:0]       core_be_i,
    input  logic [DATA_WIDTH-1:0]     core_wdata_i,
    output logic                      core_rvalid_o,
    output logic [DATA_WIDTH-1:0]     core_rdata_o,
    output logic                      core_err_o,

`ifdef MEM_ARB_PERF_EN
    input  logic                      perf_clr_i,
    output logic [PERF_CNT_WIDTH-1:0] conflict_cnt_o,
`endif

    output logic                      ram_en_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic                      ram_we_o,
    output logic [BE_WIDTH-1:0]       ram_be_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    owner_e                owner_q;
    owner_e                owner_d;
    logic                  core_we_q;
    logic                  core_we_d;
    logic                  core_in_range;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Addresses at or above the implemented depth never touch the macro.
    assign core_in_range = 32'(core_addr_i) < NUM_WORDS;

    // AXI read data comes straight from the macro, one cycle after its request.
    assign axi_rdata_o = ram_rdata_i;

    // Owner register plus the direction of the last granted core access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            core_we_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            core_we_q <= core_we_d;
        end
    end

    // Arbitration, SRAM request mux and next owner.
    always_comb begin
        owner_d     = OWN_NONE;
        core_we_d   = 1'b0;
        core_gnt_o  = core_req_i & ~axi_req_i;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;

        if (axi_req_i) begin
            owner_d     = OWN_AXI;
            ram_en_o    = 1'b1;
            ram_addr_o  = axi_addr_i;
            ram_we_o    = axi_we_i;
            ram_be_o    = axi_be_i;
            ram_wdata_o = axi_wdata_i;
        end else if (core_req_i) begin
            core_we_d = core_we_i;
            if (core_in_range) begin
                owner_d     = OWN_CORE;
                ram_en_o    = 1'b1;
                ram_addr_o  = core_addr_i;
                ram_we_o    = core_we_i;
                ram_be_o    = core_be_i;
                ram_wdata_o = core_wdata_i;
            end else begin
                owner_d = OWN_CORE_ERR;
            end
        end
    end

    // Held copy of the last core response data; AXI traffic never updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (owner_q == OWN_CORE && !core_we_q) begin
            rdata_q <= ram_rdata_i;
        end else if (owner_q == OWN_CORE_ERR) begin
            rdata_q <= '0;
        end
    end

    // Response is decoded from the owner register; data is live only in the rvalid cycle.
    always_comb begin
        core_rvalid_o = owner_is_core(owner_q);
        core_err_o    = (owner_q == OWN_CORE_ERR);
        core_rdata_o  = rdata_q;
        if (owner_q == OWN_CORE && !core_we_q) begin
            core_rdata_o = ram_rdata_i;
        end else if (owner_q == OWN_CORE_ERR) begin
            core_rdata_o = '0;
        end
    end

`ifdef MEM_ARB_PERF_EN
    sp_mem_arbiter_perf_cnt u_perf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr_i),
        .inc   (axi_req_i & core_req_i),
        .count (conflict_cnt_o)
    );
`endif

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed self-checking bench for sp_mem_arbiter with a behavioural 1-cycle SRAM.
// Conflict-counter checks are compiled in when MEM_ARB_PERF_EN is defined.
module tb_sp_mem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned NW = 512;

    logic          clk;
    logic          rst_n;
    logic          axi_req;
    logic [AW-1:0] axi_addr;
    logic          axi_we;
    logic [BW-1:0] axi_be;
    logic [DW-1:0] axi_wdata;
    logic [DW-1:0] axi_rdata;
    logic          core_req;
    logic          core_gnt;
    logic [AW-1:0] core_addr;
    logic          core_we;
    logic [BW-1:0] core_be;
    logic [DW-1:0] core_wdata;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          core_err;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef MEM_ARB_PERF_EN
    logic          perf_clr;
    logic [31:0]   conflict_cnt;
`endif

    int n_checks;
    int n_errors;

    logic [DW-1:0] mem [1024];

    sp_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .NUM_WORDS  (NW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi_req_i      (axi_req),
        .axi_addr_i     (axi_addr),
        .axi_we_i       (axi_we),
        .axi_be_i       (axi_be),
        .axi_wdata_i    (axi_wdata),
        .axi_rdata_o    (axi_rdata),
        .core_req_i     (core_req),
        .core_gnt_o     (core_gnt),
        .core_addr_i    (core_addr),
        .core_we_i      (core_we),
        .core_be_i      (core_be),
        .core_wdata_i   (core_wdata),
        .core_rvalid_o  (core_rvalid),
        .core_rdata_o   (core_rdata),
        .core_err_o     (core_err),
`ifdef MEM_ARB_PERF_EN
        .perf_clr_i     (perf_clr),
        .conflict_cnt_o (conflict_cnt),
`endif
        .ram_en_o       (ram_en),
        .ram_addr_o     (ram_addr),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: byte-masked writes, registered read data held between reads.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < int'(BW); b++) begin
                    if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        axi_req   = 1'b1;
        axi_we    = 1'b1;
        axi_be    = '1;
        axi_addr  = a;
        axi_wdata = d;
        step();
        axi_req   = 1'b0;
        axi_we    = 1'b0;
    endtask

    task automatic core_rd(input logic [AW-1:0] a);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_be   = '1;
        core_addr = a;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        axi_req    = 1'b0;
        axi_addr   = '0;
        axi_we     = 1'b0;
        axi_be     = '0;
        axi_wdata  = '0;
        core_req   = 1'b0;
        core_addr  = '0;
        core_we    = 1'b0;
        core_be    = '0;
        core_wdata = '0;
        ram_rdata  = '0;
`ifdef MEM_ARB_PERF_EN
        perf_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_rvalid", 64'(core_rvalid), 64'd0);
        check("rst_err",    64'(core_err),    64'd0);
        check("rst_rdata",  64'(core_rdata),  64'd0);
        check("rst_ram_en", 64'(ram_en),      64'd0);
        check("rst_ram_addr", 64'(ram_addr),  64'd0);
        check("rst_gnt",    64'(core_gnt),    64'd0);
        step();

        axi_wr(10'h010, 64'hDEADBEEF_0000_0001);
        axi_wr(10'h030, 64'h0123_4567_89AB_CDEF);
        axi_wr(10'h040, 64'hA5A5_A5A5_A5A5_A5A5);
        axi_wr(10'h041, 64'h5A5A_5A5A_5A5A_5A5A);
        check("axi_wr_no_rvalid", 64'(core_rvalid), 64'd0);

        // Core read with AXI idle.
        core_rd(10'h010);
        #1;
        check("t1_gnt",      64'(core_gnt),  64'd1);
        check("t1_ram_en",   64'(ram_en),    64'd1);
        check("t1_ram_addr", 64'(ram_addr),  64'h010);
        check("t1_ram_we",   64'(ram_we),    64'd0);
        step();
        core_req = 1'b0;
        check("t1_rvalid", 64'(core_rvalid), 64'd1);
        check("t1_rdata",  64'(core_rdata),  64'hDEADBEEF_0000_0001);
        check("t1_err",    64'(core_err),    64'd0);
        step();
        check("t1_rvalid_drop", 64'(core_rvalid), 64'd0);
        check("t1_rdata_hold",  64'(core_rdata),  64'hDEADBEEF_0000_0001);

        // Simultaneous AXI write and core read of the same word.
        axi_req   = 1'b1;
        axi_we    = 1'b1;
        axi_be    = '1;
        axi_addr  = 10'h020;
        axi_wdata = 64'h1122_3344_5566_7788;
        core_rd(10'h020);
        #1;
        check("t2_gnt0",      64'(core_gnt),  64'd0);
        check("t2_ram_we",    64'(ram_we),    64'd1);
        check("t2_ram_addr",  64'(ram_addr),  64'h020);
        check("t2_ram_wdata", 64'(ram_wdata), 64'h1122_3344_5566_7788);
        step();
        axi_req = 1'b0;
        axi_we  = 1'b0;
        check("t2_rvalid0", 64'(core_rvalid), 64'd0);
        #1;
        check("t2_gnt1",    64'(core_gnt), 64'd1);
        check("t2_ram_we1", 64'(ram_we),   64'd0);
        step();
        core_req = 1'b0;
        check("t2_rvalid1", 64'(core_rvalid), 64'd1);
        check("t2_rdata",   64'(core_rdata),  64'h1122_3344_5566_7788);

        // Last in-range word and first/far out-of-range words.
        core_rd(10'h1FF);
        #1;
        check("t3_last_ram_en", 64'(ram_en), 64'd1);
        step();
        check("t3_last_err", 64'(core_err), 64'd0);
        core_rd(10'h3FF);
        #1;
        check("t3_gnt",      64'(core_gnt), 64'd1);
        check("t3_ram_en",   64'(ram_en),   64'd0);
        check("t3_ram_addr", 64'(ram_addr), 64'd0);
        step();
        core_rd(10'h200);
        check("t3_rvalid", 64'(core_rvalid), 64'd1);
        check("t3_err",    64'(core_err),    64'd1);
        check("t3_rdata",  64'(core_rdata),  64'd0);
        #1;
        check("t3_edge_ram_en", 64'(ram_en), 64'd0);
        step();
        core_req = 1'b0;
        check("t3_edge_err", 64'(core_err), 64'd1);
        step();
        check("t3_rvalid_drop", 64'(core_rvalid), 64'd0);
        check("t3_err_drop",    64'(core_err),    64'd0);

        // Partial write, then back-to-back reads.
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_be    = 8'h0F;
        core_addr  = 10'h030;
        core_wdata = '1;
        #1;
        check("t4_ram_be", 64'(ram_be), 64'h0F);
        check("t4_ram_we", 64'(ram_we), 64'd1);
        step();
        core_rd(10'h030);
        check("t4_wr_rvalid", 64'(core_rvalid), 64'd1);
        check("t4_wr_err",    64'(core_err),    64'd0);
        check("t4_wr_rdata",  64'(core_rdata),  64'd0);
        step();
        core_rd(10'h010);
        check("t4_b2b_rvalid0", 64'(core_rvalid), 64'd1);
        check("t4_b2b_rdata0",  64'(core_rdata),  64'h0123_4567_FFFF_FFFF);
        step();
        core_req = 1'b0;
        check("t4_b2b_rvalid1", 64'(core_rvalid), 64'd1);
        check("t4_b2b_rdata1",  64'(core_rdata),  64'hDEADBEEF_0000_0001);
        step();

        // Core rdata holds across a later AXI read.
        core_rd(10'h040);
        step();
        core_req = 1'b0;
        check("t5_rdata", 64'(core_rdata), 64'hA5A5_A5A5_A5A5_A5A5);
        axi_req  = 1'b1;
        axi_we   = 1'b0;
        axi_addr = 10'h041;
        step();
        axi_req = 1'b0;
        check("t5_axi_rdata",  64'(axi_rdata),   64'h5A5A_5A5A_5A5A_5A5A);
        check("t5_core_hold",  64'(core_rdata),  64'hA5A5_A5A5_A5A5_A5A5);
        check("t5_rvalid",     64'(core_rvalid), 64'd0);
        step();
        check("t5_core_hold2", 64'(core_rdata),  64'hA5A5_A5A5_A5A5_A5A5);

        // Reset between grant and response.
        core_rd(10'h010);
        #1;
        check("t6_gnt", 64'(core_gnt), 64'd1);
        #1 rst_n = 1'b0;
        step();
        core_req = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("t6_rvalid", 64'(core_rvalid), 64'd0);
        check("t6_err",    64'(core_err),    64'd0);
        check("t6_rdata",  64'(core_rdata),  64'd0);
        check("t6_ram_en", 64'(ram_en),      64'd0);
        step();
        check("t6_rvalid_after", 64'(core_rvalid), 64'd0);

`ifdef MEM_ARB_PERF_EN
        // Conflict counting, saturating counter clear priority.
        check("p_cnt_rst", 64'(conflict_cnt), 64'd0);
        axi_req  = 1'b1;
        axi_we   = 1'b0;
        axi_addr = 10'h010;
        core_rd(10'h010);
        repeat (5) step();
        axi_req  = 1'b0;
        core_req = 1'b0;
        check("p_cnt5", 64'(conflict_cnt), 64'd5);
        step();
        check("p_cnt5_idle", 64'(conflict_cnt), 64'd5);
        axi_req  = 1'b1;
        core_req = 1'b1;
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("p_clr", 64'(conflict_cnt), 64'd0);
        step();
        axi_req  = 1'b0;
        core_req = 1'b0;
        check("p_cnt1", 64'(conflict_cnt), 64'd1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
